// File: rtl/msrv32_lsu_pkg.sv
// Shared types and helpers for the load/store control stage.
package msrv32_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned RD_W   = 5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, WAIT} lsu_state_e;

  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_req_t;

  function automatic logic [STRB_W-1:0] wstrb_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [STRB_W-1:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << lane;
      SZ_HALF: strb = 4'b0011 << {lane[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

  // Replicate store data across every lane the strobes might select.
  function automatic logic [XLEN-1:0] st_data_fmt(input logic [1:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module msrv32_load_align
  import msrv32_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata[7:0];
    half_sel    = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data_c = rdata;
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (size)
      SZ_BYTE: load_data_c = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_c = {{16{~uns & half_sel[15]}}, half_sel};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_lsu_ctrl.sv
// Load/store control: turns one registered load/store into a data-memory
// bus transaction, stalls upstream while waiting, formats load results.
module msrv32_lsu_ctrl
  import msrv32_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ld_req_in,
  input  logic              st_req_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   st_data_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [RD_W-1:0]   rd_addr_in,
  output logic              dmem_req_out,
  output logic              dmem_we_out,
  output logic [XLEN-1:0]   dmem_addr_out,
  output logic [XLEN-1:0]   dmem_wdata_out,
  output logic [STRB_W-1:0] dmem_wstrb_out,
  input  logic              dmem_ready_in,
  input  logic [XLEN-1:0]   dmem_rdata_in,
  output logic              stall_out,
  output logic [XLEN-1:0]   load_data_out,
  output logic              load_valid_out,
  output logic [RD_W-1:0]   load_rd_addr_out,
  output logic              misaligned_ld_out,
  output logic              misaligned_st_out,
  output logic              bus_err_out
);

  // Counter holds completed no-ready WAIT cycles; the last allowed one is TO_LAST.
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         bus_q, bus_d;
  logic              req_q, req_d;
  logic [1:0]        lane_q, lane_d, size_q, size_d;
  logic              uns_q, uns_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic [RD_W-1:0]   load_rd_q, load_rd_d;
  logic              load_valid_q, load_valid_d;
  logic              mis_ld_q, mis_ld_d, mis_st_q, mis_st_d, bus_err_q, bus_err_d;
  logic              req_any_c, mis_c;
  logic [XLEN-1:0]   aligned_c;

  msrv32_load_align u_align (
    .rdata       (dmem_rdata_in),
    .lane        (lane_q),
    .size        (size_q),
    .uns         (uns_q),
    .load_data_c (aligned_c)
  );

  assign req_any_c = ld_req_in | st_req_in;
  assign mis_c     = misaligned(size_in, addr_in[1:0]);
  assign stall_out = ((state_q == IDLE) && req_any_c && !mis_c) ||
                     ((state_q == WAIT) && !dmem_ready_in);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    req_d        = req_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    load_valid_d = 1'b0;
    mis_ld_d     = 1'b0;
    mis_st_d     = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any_c) begin
          if (mis_c) begin
            mis_ld_d = ld_req_in;
            mis_st_d = !ld_req_in;
          end else begin
            state_d     = WAIT;
            req_d       = 1'b1;
            cnt_d       = '0;
            bus_d.we    = !ld_req_in;
            bus_d.addr  = {addr_in[XLEN-1:2], 2'b00};
            bus_d.wdata = ld_req_in ? '0 : st_data_fmt(size_in, st_data_in);
            bus_d.wstrb = ld_req_in ? '0 : wstrb_gen(size_in, addr_in[1:0]);
            lane_d      = addr_in[1:0];
            size_d      = size_in;
            uns_d       = unsigned_in;
            rd_d        = rd_addr_in;
          end
        end
      end
      WAIT: begin
        if (dmem_ready_in) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          bus_d   = '0;
          if (!bus_q.we) begin
            load_valid_d = 1'b1;
            load_data_d  = aligned_c;
            load_rd_d    = rd_q;
          end
        end else if (TO_EN && (cnt_q == CNT_W'(TO_LAST))) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          cnt_d     = '0;
          bus_d     = '0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_q        <= '0;
      req_q        <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      load_valid_q <= 1'b0;
      mis_ld_q     <= 1'b0;
      mis_st_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      req_q        <= req_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
      load_valid_q <= load_valid_d;
      mis_ld_q     <= mis_ld_d;
      mis_st_q     <= mis_st_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req_out      = req_q;
  assign dmem_we_out       = bus_q.we;
  assign dmem_addr_out     = bus_q.addr;
  assign dmem_wdata_out    = bus_q.wdata;
  assign dmem_wstrb_out    = bus_q.wstrb;
  assign load_data_out     = load_data_q;
  assign load_valid_out    = load_valid_q;
  assign load_rd_addr_out  = load_rd_q;
  assign misaligned_ld_out = mis_ld_q;
  assign misaligned_st_out = mis_st_q;
  assign bus_err_out       = bus_err_q;

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Scoreboard bench for msrv32_lsu_ctrl: stimulus pushes expectations,
// a negedge monitor pops and compares bus requests, loads and pulses.
module tb_msrv32_lsu_ctrl;

  localparam int EV_MLD  = 1;
  localparam int EV_MST  = 2;
  localparam int EV_BERR = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_ld_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        ld_req_in = 1'b0, st_req_in = 1'b0;
  logic [31:0] addr_in = '0, st_data_in = '0;
  logic [1:0]  size_in = '0;
  logic        unsigned_in = 1'b0;
  logic [4:0]  rd_addr_in = '0;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_wstrb_out;
  logic        dmem_ready_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic [4:0]  load_rd_addr_out;
  logic        misaligned_ld_out, misaligned_st_out, bus_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  exp_req_t q_req[$];
  exp_ld_t  q_ld[$];
  int       q_ev[$];

  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .ld_req_in         (ld_req_in),
    .st_req_in         (st_req_in),
    .addr_in           (addr_in),
    .st_data_in        (st_data_in),
    .size_in           (size_in),
    .unsigned_in       (unsigned_in),
    .rd_addr_in        (rd_addr_in),
    .dmem_req_out      (dmem_req_out),
    .dmem_we_out       (dmem_we_out),
    .dmem_addr_out     (dmem_addr_out),
    .dmem_wdata_out    (dmem_wdata_out),
    .dmem_wstrb_out    (dmem_wstrb_out),
    .dmem_ready_in     (dmem_ready_in),
    .dmem_rdata_in     (dmem_rdata_in),
    .stall_out         (stall_out),
    .load_data_out     (load_data_out),
    .load_valid_out    (load_valid_out),
    .load_rd_addr_out  (load_rd_addr_out),
    .misaligned_ld_out (misaligned_ld_out),
    .misaligned_st_out (misaligned_st_out),
    .bus_err_out       (bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output asserted with nothing expected at %0t", name, $time);
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.wstrb = ws;
    q_req.push_back(r);
  endtask

  task automatic push_ld(input logic [31:0] d, input logic [4:0] rd);
    exp_ld_t l;
    l.data = d; l.rd = rd;
    q_ld.push_back(l);
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  exp_req_t cur_req;
  logic prev_req = 1'b0, prev_lv = 1'b0, prev_ml = 1'b0, prev_ms = 1'b0, prev_be = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (dmem_req_out) begin
        if (!prev_req) begin
          if (q_req.size() == 0) unexpected("dmem_req");
          else cur_req = q_req.pop_front();
        end
        chk("dmem_we", dmem_we_out, cur_req.we);
        chk("dmem_addr", dmem_addr_out, cur_req.addr);
        chk("dmem_wdata", dmem_wdata_out, cur_req.wdata);
        chk("dmem_wstrb", dmem_wstrb_out, cur_req.wstrb);
      end
      if (load_valid_out) begin
        chk("load_valid_width", prev_lv, 0);
        if (q_ld.size() == 0) unexpected("load_valid");
        else begin
          exp_ld_t l;
          l = q_ld.pop_front();
          chk("load_data", load_data_out, l.data);
          chk("load_rd", load_rd_addr_out, l.rd);
        end
      end
      if (misaligned_ld_out || misaligned_st_out || bus_err_out) begin
        int kind;
        kind = misaligned_ld_out ? EV_MLD : misaligned_st_out ? EV_MST : EV_BERR;
        chk("pulse_width", prev_ml | prev_ms | prev_be, 0);
        chk("pulse_onehot", 32'(misaligned_ld_out) + 32'(misaligned_st_out) + 32'(bus_err_out), 1);
        if (q_ev.size() == 0) unexpected("event_pulse");
        else chk("event_kind", kind, q_ev.pop_front());
      end
    end
    prev_req = dmem_req_out;
    prev_lv  = load_valid_out;
    prev_ml  = misaligned_ld_out;
    prev_ms  = misaligned_st_out;
    prev_be  = bus_err_out;
  end

  // Present one request at posedge+1; memory answers after dly no-ready WAIT cycles.
  task automatic issue(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                       input logic [31:0] rdata, input int dly, input logic exp_mis);
    ld_req_in = ld; st_req_in = st; addr_in = a; st_data_in = d;
    size_in = sz; unsigned_in = uns; rd_addr_in = rd;
    @(negedge clk_in) chk("stall_accept", stall_out, !exp_mis);
    @(posedge clk_in) #1;
    ld_req_in = 1'b0; st_req_in = 1'b0;
    if (exp_mis) begin
      @(negedge clk_in);
      chk("mis_pulse_t1", misaligned_ld_out | misaligned_st_out, 1);
      chk("stall_after_mis", stall_out, 0);
      chk("req_after_mis", dmem_req_out, 0);
      @(posedge clk_in) #1;
    end else begin
      for (int i = 0; i < dly; i++) begin
        @(negedge clk_in) chk("stall_wait", stall_out, 1);
        @(posedge clk_in) #1;
      end
      dmem_ready_in = 1'b1; dmem_rdata_in = rdata;
      @(negedge clk_in) chk("stall_ready", stall_out, 0);
      @(posedge clk_in) #1;
      dmem_ready_in = 1'b0; dmem_rdata_in = '0;
      @(negedge clk_in);
      chk("load_valid_timing", load_valid_out, ld);
      chk("req_done", dmem_req_out, 0);
      @(posedge clk_in) #1;
    end
  endtask

  initial begin
    int hi;
    // Reset state
    @(negedge clk_in);
    chk("rst_req", dmem_req_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_load_data", load_data_out, 0);
    chk("rst_pulses", {load_valid_out, misaligned_ld_out, misaligned_st_out, bus_err_out}, 0);
    @(posedge clk_in) #1 rst_in = 1'b1;
    @(posedge clk_in) #1;

    // Signed byte load, lane 3, immediate ready
    push_req(0, 32'h0000_1000, 0, 4'b0000); push_ld(32'hFFFF_FF80, 5'd5);
    issue(1, 0, 32'h0000_1003, 0, 2'b00, 0, 5'd5, 32'h8012_3456, 0, 0);

    // Half store, upper lane, ready after 3 cycles
    push_req(1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    issue(0, 1, 32'h0000_2002, 32'h0000_BEEF, 2'b01, 0, 5'd0, 0, 3, 0);
    chk("load_data_hold", load_data_out, 32'hFFFF_FF80);

    // Misaligned word load, misaligned half store
    q_ev.push_back(EV_MLD);
    issue(1, 0, 32'h0000_3001, 0, 2'b10, 0, 5'd1, 0, 0, 1);
    q_ev.push_back(EV_MST);
    issue(0, 1, 32'h0000_7003, 32'h1234, 2'b01, 0, 5'd0, 0, 0, 1);

    // Timeout: request held for exactly 4 WAIT cycles, one bus error
    push_req(0, 32'h0000_5000, 0, 4'b0000); q_ev.push_back(EV_BERR);
    ld_req_in = 1; addr_in = 32'h0000_5000; size_in = 2'b10; rd_addr_in = 5'd7;
    @(negedge clk_in) chk("stall_accept_to", stall_out, 1);
    @(posedge clk_in) #1 ld_req_in = 0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in) if (dmem_req_out) hi++;
    end
    chk("timeout_req_cycles", 32'(hi), 4);
    @(posedge clk_in) #1;

    // Normal load after timeout
    push_req(0, 32'h0000_6000, 0, 4'b0000); push_ld(32'hCAFE_F00D, 5'd8);
    issue(1, 0, 32'h0000_6000, 0, 2'b10, 0, 5'd8, 32'hCAFE_F00D, 1, 0);

    // Unsigned and signed half loads
    push_req(0, 32'h0000_4000, 0, 4'b0000); push_ld(32'h0000_F00D, 5'd10);
    issue(1, 0, 32'h0000_4002, 0, 2'b01, 1, 5'd10, 32'hF00D_1234, 0, 0);
    push_req(0, 32'h0000_4000, 0, 4'b0000); push_ld(32'hFFFF_F00D, 5'd11);
    issue(1, 0, 32'h0000_4002, 0, 2'b01, 0, 5'd11, 32'hF00D_1234, 2, 0);

    // Byte store lane 1, word store, unsigned byte load lane 0
    push_req(1, 32'h0000_7000, 32'hA5A5_A5A5, 4'b0010);
    issue(0, 1, 32'h0000_7001, 32'h0000_00A5, 2'b00, 0, 5'd0, 0, 1, 0);
    push_req(1, 32'h0000_9000, 32'h1234_5678, 4'b1111);
    issue(0, 1, 32'h0000_9000, 32'h1234_5678, 2'b10, 0, 5'd0, 0, 0, 0);
    push_req(0, 32'h0000_8000, 0, 4'b0000); push_ld(32'h0000_00FF, 5'd12);
    issue(1, 0, 32'h0000_8000, 0, 2'b00, 1, 5'd12, 32'h1234_56FF, 0, 0);

    // Simultaneous load+store acts as load; size 11 is word
    push_req(0, 32'h0000_C000, 0, 4'b0000); push_ld(32'h0BAD_F00D, 5'd9);
    issue(1, 1, 32'h0000_C000, 32'hDEAD, 2'b10, 0, 5'd9, 32'h0BAD_F00D, 0, 0);
    push_req(0, 32'h0000_D004, 0, 4'b0000); push_ld(32'h89AB_CDEF, 5'd13);
    issue(1, 0, 32'h0000_D004, 0, 2'b11, 0, 5'd13, 32'h89AB_CDEF, 1, 0);

    // Asynchronous reset in the middle of a WAIT
    push_req(1, 32'h0000_A000, 32'h1122_3344, 4'b1111);
    st_req_in = 1; addr_in = 32'h0000_A000; st_data_in = 32'h1122_3344; size_in = 2'b10;
    @(posedge clk_in) #1 st_req_in = 0;
    @(posedge clk_in) #3 rst_in = 1'b0;
    #1;
    chk("req_async_reset", dmem_req_out, 0);
    chk("stall_async_reset", stall_out, 0);
    chk("load_data_async_reset", load_data_out, 0);
    @(posedge clk_in) #1;
    @(posedge clk_in) #1 rst_in = 1'b1;
    @(posedge clk_in) #1;

    // Store after reset
    push_req(1, 32'h0000_B000, 32'h5A5A_5A5A, 4'b1000);
    issue(0, 1, 32'h0000_B003, 32'h0000_005A, 2'b00, 0, 5'd0, 0, 0, 0);

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("req_queue_empty", 32'(q_req.size()), 0);
    chk("ld_queue_empty", 32'(q_ld.size()), 0);
    chk("ev_queue_empty", 32'(q_ev.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
